// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per clock.
// The divider datapath is present only when MULT_DIV_UNIT_DIVIDE_EN is defined; otherwise DIV/DIVU are illegal.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  DivByZero,
    output logic                  IllegalOp
);

    localparam int unsigned W        = DATA_WIDTH;
    localparam logic [5:0]  LastIter = 6'(W - 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
`endif
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StRun, StFix} stateT;

    stateT          stateQ, stateD;
    logic [5:0]     cntQ, cntD;
    logic [W-1:0]   hiQ, hiD;
    logic [W-1:0]   loQ, loD;
    logic [W-1:0]   accHiQ, accHiD;
    logic [W-1:0]   accLoQ, accLoD;
    logic [W-1:0]   opAQ, opAD;
    logic           negResQ, negResD;
    logic           doneQ, doneD;
    logic           illegalQ, illegalD;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    logic           isDivQ, isDivD;
    logic           negRemQ, negRemD;
    logic           dbzQ, dbzD;
    logic [W-1:0]   aRawQ, aRawD;
    logic [W:0]     divShift;
    logic [W:0]     divDiff;
    logic [W-1:0]   quotFix;
    logic [W-1:0]   remFix;
`endif

    logic           opSigned;
    logic [W-1:0]   magA;
    logic [W-1:0]   magB;
    logic [W:0]     mulSum;
    logic [2*W-1:0] product;
    logic [2*W-1:0] productFix;

    // MULT and DIV (even opcodes) take signed operands; iterate on magnitudes.
    assign opSigned = ~Op[0];
    assign magA     = (opSigned && A[W-1]) ? -A : A;
    assign magB     = (opSigned && B[W-1]) ? -B : B;

    // accHi is the running partial product, accLo the multiplier shifting out as product bits shift in.
    assign mulSum     = {1'b0, accHiQ} + (accLoQ[0] ? {1'b0, opAQ} : '0);
    assign product    = {accHiQ, accLoQ};
    assign productFix = negResQ ? -product : product;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    // accHi is the partial remainder, accLo the dividend shifting out as quotient bits shift in.
    assign divShift = {accHiQ, accLoQ[W-1]};
    assign divDiff  = divShift - {1'b0, opAQ};
    assign quotFix  = negResQ ? -accLoQ : accLoQ;
    assign remFix   = negRemQ ? -accHiQ : accHiQ;
`endif

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        hiD      = hiQ;
        loD      = loQ;
        accHiD   = accHiQ;
        accLoD   = accLoQ;
        opAD     = opAQ;
        negResD  = negResQ;
        doneD    = 1'b0;
        illegalD = 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        isDivD   = isDivQ;
        negRemD  = negRemQ;
        dbzD     = dbzQ;
        aRawD    = aRawQ;
`endif

        case (stateQ)
            StIdle: begin
                if (Start) begin
                    case (Op)
                        OpMult, OpMultu: begin
                            stateD  = StRun;
                            cntD    = '0;
                            accHiD  = '0;
                            accLoD  = magB;
                            opAD    = magA;
                            negResD = opSigned & (A[W-1] ^ B[W-1]);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                            isDivD  = 1'b0;
                            dbzD    = 1'b0;
`endif
                        end
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        OpDiv, OpDivu: begin
                            stateD  = StRun;
                            cntD    = '0;
                            accHiD  = '0;
                            accLoD  = magA;
                            opAD    = magB;
                            negResD = opSigned & (A[W-1] ^ B[W-1]);
                            negRemD = opSigned & A[W-1];
                            isDivD  = 1'b1;
                            dbzD    = (B == '0);
                            aRawD   = A;
                        end
`endif
                        OpMthi:  hiD      = A;
                        OpMtlo:  loD      = A;
                        default: illegalD = 1'b1;
                    endcase
                end
            end

            StRun: begin
                cntD = cntQ + 6'd1;
                if (cntQ == LastIter) begin
                    stateD = StFix;
                end
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                if (isDivQ) begin
                    // Borrow out of divDiff means the divisor did not fit: restore.
                    if (!divDiff[W]) begin
                        accHiD = divDiff[W-1:0];
                        accLoD = {accLoQ[W-2:0], 1'b1};
                    end else begin
                        accHiD = divShift[W-1:0];
                        accLoD = {accLoQ[W-2:0], 1'b0};
                    end
                end else begin
                    {accHiD, accLoD} = {mulSum, accLoQ[W-1:1]};
                end
`else
                {accHiD, accLoD} = {mulSum, accLoQ[W-1:1]};
`endif
            end

            StFix: begin
                stateD = StIdle;
                cntD   = '0;
                doneD  = 1'b1;
                hiD    = productFix[2*W-1:W];
                loD    = productFix[W-1:0];
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                if (isDivQ) begin
                    if (dbzQ) begin
                        loD = '1;
                        hiD = aRawQ;
                    end else begin
                        loD = quotFix;
                        hiD = remFix;
                    end
                end
`endif
            end

            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            hiQ      <= '0;
            loQ      <= '0;
            accHiQ   <= '0;
            accLoQ   <= '0;
            opAQ     <= '0;
            negResQ  <= 1'b0;
            doneQ    <= 1'b0;
            illegalQ <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            isDivQ   <= 1'b0;
            negRemQ  <= 1'b0;
            dbzQ     <= 1'b0;
            aRawQ    <= '0;
`endif
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            hiQ      <= hiD;
            loQ      <= loD;
            accHiQ   <= accHiD;
            accLoQ   <= accLoD;
            opAQ     <= opAD;
            negResQ  <= negResD;
            doneQ    <= doneD;
            illegalQ <= illegalD;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            isDivQ   <= isDivD;
            negRemQ  <= negRemD;
            dbzQ     <= dbzD;
            aRawQ    <= aRawD;
`endif
        end
    end

    assign Busy      = (stateQ != StIdle);
    assign Done      = doneQ;
    assign HI        = hiQ;
    assign LO        = loQ;
    assign IllegalOp = illegalQ;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    assign DivByZero = dbzQ;
`else
    assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized operations
// checked against an arithmetic HI/LO model. Honours MULT_DIV_UNIT_DIVIDE_EN like the design.
module tb_mult_div_unit;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DivByZero;
    logic        IllegalOp;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] hiM;
    logic [31:0] loM;
    logic        dbzM;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .HI        (HI),
        .LO        (LO),
        .DivByZero (DivByZero),
        .IllegalOp (IllegalOp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the architectural HI/LO state.
    task automatic model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [63:0] sa, sb, sq, sr;
        case (op)
            OpMult, OpMultu: begin
                ea   = (op == OpMult) ? {{32{a[31]}}, a} : {32'h0, a};
                eb   = (op == OpMult) ? {{32{b[31]}}, b} : {32'h0, b};
                p    = ea * eb;
                hiM  = p[63:32];
                loM  = p[31:0];
                dbzM = 1'b0;
            end
            OpDiv, OpDivu: begin
                if (b == 32'h0) begin
                    loM  = 32'hFFFF_FFFF;
                    hiM  = a;
                    dbzM = 1'b1;
                end else begin
                    dbzM = 1'b0;
                    if (op == OpDiv) begin
                        sa  = {{32{a[31]}}, a};
                        sb  = {{32{b[31]}}, b};
                        sq  = sa / sb;
                        sr  = sa % sb;
                        loM = sq[31:0];
                        hiM = sr[31:0];
                    end else begin
                        loM = a / b;
                        hiM = a % b;
                    end
                end
            end
            OpMthi:  hiM = a;
            OpMtlo:  loM = a;
            default: ;
        endcase
    endtask

    // Issues one multi-cycle op, scrambles A/B after acceptance, waits (bounded) for Done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit overlap, output bit busyE0);
        bit got;
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0; A = $urandom; B = $urandom;
        busyE0 = Busy; lat = 0; overlap = 1'b0; got = 1'b0;
        while (lat < 40 && !got) begin
            tick();
            lat++;
            if (Busy && Done) overlap = 1'b1;
            got = Done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; Op = 3'b000; A = '0; B = '0;
        repeat (2) tick();
        nCompared++; if (Busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy: got %b want 0", Busy); end
        nCompared++; if (Done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b want 0", Done); end
        nCompared++; if (HI !== 32'h0) begin nMismatched++; $display("FAIL reset_hi: got %h want 0", HI); end
        nCompared++; if (LO !== 32'h0) begin nMismatched++; $display("FAIL reset_lo: got %h want 0", LO); end
        nCompared++; if (DivByZero !== 1'b0) begin nMismatched++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
        nCompared++; if (IllegalOp !== 1'b0) begin nMismatched++; $display("FAIL reset_ill: got %b want 0", IllegalOp); end
        reset = 1'b0;
        hiM = '0; loM = '0; dbzM = 1'b0;
    endtask

    task automatic test_mult_directed();
        int lat; bit ov, be;
        run_op(OpMultu, 32'hFFFF_FFFF, 32'd2, lat, ov, be);
        model_exec(OpMultu, 32'hFFFF_FFFF, 32'd2);
        nCompared++; if (be !== 1'b1) begin nMismatched++; $display("FAIL multu_busy_e0: got %b want 1", be); end
        nCompared++; if (lat != 33) begin nMismatched++; $display("FAIL multu_latency: got %0d want 33", lat); end
        nCompared++; if (ov !== 1'b0) begin nMismatched++; $display("FAIL multu_busy_done_overlap: got %b want 0", ov); end
        nCompared++; if (HI !== 32'h0000_0001) begin nMismatched++; $display("FAIL multu_hi: got %h want 00000001", HI); end
        nCompared++; if (LO !== 32'hFFFF_FFFE) begin nMismatched++; $display("FAIL multu_lo: got %h want fffffffe", LO); end
        nCompared++; if (Busy !== 1'b0) begin nMismatched++; $display("FAIL multu_busy_at_done: got %b want 0", Busy); end
        tick();
        nCompared++; if (Done !== 1'b0) begin nMismatched++; $display("FAIL multu_done_width: got %b want 0", Done); end
        nCompared++; if (HI !== hiM || LO !== loM) begin nMismatched++; $display("FAIL multu_hold: got %h_%h want %h_%h", HI, LO, hiM, loM); end

        run_op(OpMult, 32'hFFFF_FFFD, 32'd7, lat, ov, be);
        model_exec(OpMult, 32'hFFFF_FFFD, 32'd7);
        nCompared++; if (lat != 33) begin nMismatched++; $display("FAIL mult_latency: got %0d want 33", lat); end
        nCompared++; if (HI !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        nCompared++; if (LO !== 32'hFFFF_FFEB) begin nMismatched++; $display("FAIL mult_lo: got %h want ffffffeb", LO); end
    endtask

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    task automatic test_divide();
        int lat; bit ov, be;
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, lat, ov, be);
        model_exec(OpDiv, 32'hFFFF_FFF9, 32'd2);
        nCompared++; if (lat != 33) begin nMismatched++; $display("FAIL div_latency: got %0d want 33", lat); end
        nCompared++; if (LO !== 32'hFFFF_FFFD) begin nMismatched++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        nCompared++; if (HI !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL div_hi: got %h want ffffffff", HI); end

        run_op(OpDivu, 32'd100, 32'd0, lat, ov, be);
        model_exec(OpDivu, 32'd100, 32'd0);
        nCompared++; if (lat != 33) begin nMismatched++; $display("FAIL divz_latency: got %0d want 33", lat); end
        nCompared++; if (LO !== 32'hFFFF_FFFF) begin nMismatched++; $display("FAIL divz_lo: got %h want ffffffff", LO); end
        nCompared++; if (HI !== 32'd100) begin nMismatched++; $display("FAIL divz_hi: got %h want 00000064", HI); end
        nCompared++; if (DivByZero !== 1'b1) begin nMismatched++; $display("FAIL divz_flag: got %b want 1", DivByZero); end

        Start = 1'b1; Op = OpMthi; A = 32'hCAFE_F00D;
        tick();
        Start = 1'b0;
        model_exec(OpMthi, 32'hCAFE_F00D, 32'h0);
        nCompared++; if (DivByZero !== 1'b1) begin nMismatched++; $display("FAIL divz_kept_by_mthi: got %b want 1", DivByZero); end

        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, lat, ov, be);
        model_exec(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        nCompared++; if (LO !== 32'h8000_0000) begin nMismatched++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
        nCompared++; if (HI !== 32'h0) begin nMismatched++; $display("FAIL div_ovf_hi: got %h want 00000000", HI); end
        nCompared++; if (DivByZero !== 1'b0) begin nMismatched++; $display("FAIL divz_cleared: got %b want 0", DivByZero); end
    endtask
`else
    task automatic test_div_disabled();
        logic [2:0] ops [2];
        ops[0] = OpDiv; ops[1] = OpDivu;
        for (int i = 0; i < 2; i++) begin
            Start = 1'b1; Op = ops[i]; A = 32'd10; B = 32'd2;
            tick();
            Start = 1'b0;
            nCompared++; if (IllegalOp !== 1'b1) begin nMismatched++; $display("FAIL nodiv_ill_%0d: got %b want 1", i, IllegalOp); end
            nCompared++; if (Busy !== 1'b0) begin nMismatched++; $display("FAIL nodiv_busy_%0d: got %b want 0", i, Busy); end
            nCompared++; if (HI !== hiM || LO !== loM) begin nMismatched++; $display("FAIL nodiv_hilo_%0d: got %h_%h want %h_%h", i, HI, LO, hiM, loM); end
            nCompared++; if (DivByZero !== 1'b0) begin nMismatched++; $display("FAIL nodiv_dbz_%0d: got %b want 0", i, DivByZero); end
            tick();
            nCompared++; if (IllegalOp !== 1'b0 || Busy !== 1'b0) begin nMismatched++; $display("FAIL nodiv_after_%0d: got ill=%b busy=%b want 0 0", i, IllegalOp, Busy); end
        end
    endtask
`endif

    task automatic test_mthi_illegal();
        Start = 1'b1; Op = OpMthi; A = 32'h1234_5678;
        tick();
        Start = 1'b0;
        model_exec(OpMthi, 32'h1234_5678, 32'h0);
        nCompared++; if (HI !== 32'h1234_5678) begin nMismatched++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
        nCompared++; if (LO !== loM) begin nMismatched++; $display("FAIL mthi_lo: got %h want %h", LO, loM); end
        nCompared++; if (Busy !== 1'b0 || Done !== 1'b0) begin nMismatched++; $display("FAIL mthi_busy_done: got %b%b want 00", Busy, Done); end
        tick();
        nCompared++; if (Busy !== 1'b0 || Done !== 1'b0) begin nMismatched++; $display("FAIL mthi_after: got %b%b want 00", Busy, Done); end

        Start = 1'b1; Op = OpMtlo; A = 32'h9ABC_DEF0;
        tick();
        Start = 1'b0;
        model_exec(OpMtlo, 32'h9ABC_DEF0, 32'h0);
        nCompared++; if (LO !== loM || HI !== hiM) begin nMismatched++; $display("FAIL mtlo: got %h_%h want %h_%h", HI, LO, hiM, loM); end

        for (int i = 0; i < 2; i++) begin
            Start = 1'b1; Op = (i == 0) ? 3'b110 : 3'b111; A = $urandom; B = $urandom;
            tick();
            Start = 1'b0;
            nCompared++; if (IllegalOp !== 1'b1) begin nMismatched++; $display("FAIL ill_pulse_%0d: got %b want 1", i, IllegalOp); end
            nCompared++; if (HI !== hiM || LO !== loM || Busy !== 1'b0) begin nMismatched++; $display("FAIL ill_state_%0d: got %h_%h busy=%b want %h_%h busy=0", i, HI, LO, Busy, hiM, loM); end
            tick();
            nCompared++; if (IllegalOp !== 1'b0) begin nMismatched++; $display("FAIL ill_width_%0d: got %b want 0", i, IllegalOp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int lat; bit got, ov, be;
        a = $urandom; b = $urandom;
        Start = 1'b1; Op = OpMult; A = a; B = b;
        tick();
        model_exec(OpMult, a, b);
        // Keep hammering Start with other ops; all must be ignored while busy.
        lat = 0; got = 1'b0;
        while (lat < 40 && !got) begin
            Start = 1'b1; Op = lat[0] ? OpMthi : OpMultu; A = $urandom; B = $urandom;
            tick();
            lat++;
            got = Done;
        end
        Start = 1'b0;
        nCompared++; if (lat != 33) begin nMismatched++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        nCompared++; if (HI !== hiM || LO !== loM) begin nMismatched++; $display("FAIL b2b_result: got %h_%h want %h_%h", HI, LO, hiM, loM); end

        a = $urandom; b = $urandom;
        run_op(OpMultu, a, b, lat, ov, be);
        model_exec(OpMultu, a, b);
        nCompared++; if (be !== 1'b1) begin nMismatched++; $display("FAIL b2b_accept_on_done: got %b want 1", be); end
        nCompared++; if (lat != 33 || HI !== hiM || LO !== loM) begin nMismatched++; $display("FAIL b2b_second: lat=%0d got %h_%h want lat=33 %h_%h", lat, HI, LO, hiM, loM); end
    endtask

    task automatic test_abort();
        bit doneSeen;
        Start = 1'b1; Op = OpMultu; A = 32'd5; B = 32'd6;
        tick();
        Start = 1'b0;
        doneSeen = 1'b0;
        repeat (4) begin tick(); doneSeen |= Done; end
        Start = 1'b1; Op = OpMultu; A = 32'd7; B = 32'd9;
        tick();
        Start = 1'b0;
        doneSeen |= Done;
        nCompared++; if (Busy !== 1'b1) begin nMismatched++; $display("FAIL abort_busy_mid: got %b want 1", Busy); end
        repeat (4) begin tick(); doneSeen |= Done; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hiM = '0; loM = '0; dbzM = 1'b0;
        nCompared++; if (Busy !== 1'b0) begin nMismatched++; $display("FAIL abort_busy: got %b want 0", Busy); end
        nCompared++; if (HI !== 32'h0 || LO !== 32'h0) begin nMismatched++; $display("FAIL abort_hilo: got %h_%h want 0_0", HI, LO); end
        repeat (40) begin tick(); doneSeen |= Done | Busy; end
        nCompared++; if (doneSeen !== 1'b0) begin nMismatched++; $display("FAIL abort_no_done: got %b want 0", doneSeen); end

        // Reset wins over a simultaneous Start.
        reset = 1'b1; Start = 1'b1; Op = OpMultu; A = 32'd3; B = 32'd3;
        tick();
        reset = 1'b0; Start = 1'b0;
        nCompared++; if (Busy !== 1'b0) begin nMismatched++; $display("FAIL reset_over_start: got %b want 0", Busy); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int r, lat; bit ov, be;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        bit divEn = 1'b1;
`else
        bit divEn = 1'b0;
`endif
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            if (r >= 8) begin
                op = (r == 8) ? OpMthi : OpMtlo;
                Start = 1'b1; Op = op; A = a; B = b;
                tick();
                Start = 1'b0;
                model_exec(op, a, b);
                nCompared++; if (HI !== hiM || LO !== loM || Busy !== 1'b0) begin nMismatched++; $display("FAIL rand_mt_%0d: got %h_%h busy=%b want %h_%h busy=0", i, HI, LO, Busy, hiM, loM); end
            end else begin
                if (r >= 4 && divEn) begin
                    op = r[0] ? OpDivu : OpDiv;
                    if (r == 7) b = 32'h0;
                end else begin
                    op = r[0] ? OpMultu : OpMult;
                end
                run_op(op, a, b, lat, ov, be);
                model_exec(op, a, b);
                nCompared++; if (lat != 33 || ov !== 1'b0 || be !== 1'b1) begin nMismatched++; $display("FAIL rand_timing_%0d: lat=%0d ov=%b busyE0=%b want 33 0 1", i, lat, ov, be); end
                nCompared++; if (HI !== hiM || LO !== loM) begin nMismatched++; $display("FAIL rand_result_%0d op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, HI, LO, hiM, loM); end
                nCompared++; if (DivByZero !== dbzM) begin nMismatched++; $display("FAIL rand_dbz_%0d: got %b want %b", i, DivByZero, dbzM); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Op = 3'b000; A = '0; B = '0;
        test_reset();
        test_mult_directed();
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        test_divide();
`else
        test_div_disabled();
`endif
        test_mthi_illegal();
        test_back_to_back();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
